ps2_keycode_rx: RTL



---
 rtl/ps2_keycode_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, deserialises device-to-host
// frames and folds the F0 break prefix into a {prefix, scan code} keycode word.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_fall;
  logic [FW-1:0] r_fcnt;

  state_t        r_state, w_state_next;
  logic [3:0]    r_bitcnt, w_bitcnt_next;
  logic [9:0]    r_shift, w_shift_next;
  logic [TW-1:0] r_tocnt, w_tocnt_next;
  logic          r_brk, w_brk_next;
  logic          r_ext, w_ext_next;
  logic [15:0]   r_keycode, w_keycode_next;
  logic          r_key_valid, w_key_valid_next;
  logic          r_frame_err, w_frame_err_next;
  logic          w_frame_ok;
  logic [7:0]    w_byte;

  // Filtered clock only follows the pin after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fcnt <= '0;
        r_filt <= r_clk_s2;
        r_fall <= ~r_clk_s2;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_tocnt     <= '0;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_keycode   <= '0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bitcnt    <= w_bitcnt_next;
      r_shift     <= w_shift_next;
      r_tocnt     <= w_tocnt_next;
      r_brk       <= w_brk_next;
      r_ext       <= w_ext_next;
      r_keycode   <= w_keycode_next;
      r_key_valid <= w_key_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // After ten shifts: [7:0] data, [8] parity, [9] stop.
  assign w_byte     = r_shift[7:0];
  assign w_frame_ok = r_shift[9] & (^r_shift[8:0]);

  always_comb begin
    w_state_next     = r_state;
    w_bitcnt_next    = r_bitcnt;
    w_shift_next     = r_shift;
    w_tocnt_next     = r_tocnt;
    w_brk_next       = r_brk;
    w_ext_next       = r_ext;
    w_keycode_next   = r_keycode;
    w_key_valid_next = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_tocnt_next = '0;
        if (r_fall && !r_dat_s2) begin
          w_state_next  = SHIFT;
          w_bitcnt_next = '0;
        end
      end
      SHIFT: begin
        if (r_fall) begin
          w_shift_next = {r_dat_s2, r_shift[9:1]};
          w_tocnt_next = '0;
          if (r_bitcnt == 4'd9) w_state_next = CHECK;
          else w_bitcnt_next = r_bitcnt + 4'd1;
        end else if (r_tocnt == TW'(TIMEOUT_CYC)) begin
          w_state_next     = IDLE;
          w_frame_err_next = 1'b1;
        end else begin
          w_tocnt_next = r_tocnt + 1'b1;
        end
      end
      CHECK: begin
        w_state_next  = IDLE;
        w_bitcnt_next = '0;
        if (!w_frame_ok) begin
          w_frame_err_next = 1'b1;
        end else if (w_byte == 8'hF0) begin
          w_brk_next = 1'b1;
        end else if (w_byte == 8'hE0) begin
          w_ext_next = 1'b1;
        end else if (r_ext) begin
          // Extended keys are swallowed here; the decoder never sees them.
          w_brk_next = 1'b0;
          w_ext_next = 1'b0;
        end else begin
          w_keycode_next   = {(r_brk ? 8'hF0 : 8'h00), w_byte};
          w_key_valid_next = 1'b1;
          w_brk_next       = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign keycode   = r_keycode;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule
